// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for a bank of 7-segment digits that share
// one segment bus. Each digit position holds a hex value plus a decimal-point
// bit. The controller shows one digit at a time for DWELL cycles. Between
// digits it inserts a GAP-cycle blank period so that the previous digit does
// not ghost onto the next one.
//
// Parameters
//   NDIG   number of digit positions (>= 2)
//   DWELL  cycles each digit is driven (>= 1)
//   GAP    blank cycles between digits (>= 1)
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high; clears the scan and the register file
//   en       scan enable; 0 blanks the display and parks the scan in GAP
//   wr_en    write strobe for the digit register file
//   wr_addr  digit index to write (0 = rightmost); indices >= NDIG are ignored
//   wr_data  hex value to store
//   wr_dp    decimal-point bit to store
//   lzs      leading-zero suppression enable
//   sel      one-hot digit select, active-high, registered
//   seg      segment bus {dp,a,b,c,d,e,f,g}, active-high, registered
//   frame    one-cycle pulse on the first GAP cycle after the last digit
module seg7_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 1000,
  parameter int GAP   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [$clog2(NDIG)-1:0] wr_addr,
  input  logic [3:0]              wr_data,
  input  logic                    wr_dp,
  input  logic                    lzs,
  output logic [NDIG-1:0]         sel,
  output logic [7:0]              seg,
  output logic                    frame
);

  localparam int AW   = $clog2(NDIG);
  localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NDIG - 1);

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Standard active-high pattern table, segments {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h7E;
      4'h1:    p = 7'h30;
      4'h2:    p = 7'h6D;
      4'h3:    p = 7'h79;
      4'h4:    p = 7'h33;
      4'h5:    p = 7'h5B;
      4'h6:    p = 7'h5F;
      4'h7:    p = 7'h72;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h73;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h1F;
      4'hC:    p = 7'h4E;
      4'hD:    p = 7'h3D;
      4'hE:    p = 7'h4F;
      default: p = 7'h47;
    endcase
    return p;
  endfunction

  // Register file. It is built from flops rather than RAM because reset must
  // clear every entry in a single cycle.
  logic [3:0]      val_q [NDIG];
  logic [3:0]      val_d [NDIG];
  logic [NDIG-1:0] dp_q;
  logic [NDIG-1:0] dp_d;

  logic [NDIG-1:0] wr_hit;
  logic [NDIG-1:0] val_nz;
  logic [NDIG-1:0] hi_zero;

  // An out-of-range wr_addr matches no entry, so the write is dropped.
  // hi_zero[i] is set when every entry j >= i holds the value 0.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_ent
    assign wr_hit[gi]  = wr_en && (wr_addr == AW'(gi));
    assign val_nz[gi]  = |val_q[gi];
    assign hi_zero[gi] = ~|(val_nz >> gi);
  end

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      val_d[i] = val_q[i];
    end
    dp_d = dp_q;
    for (int i = 0; i < NDIG; i++) begin
      if (wr_hit[i]) begin
        val_d[i] = wr_data;
        dp_d[i]  = wr_dp;
      end
    end
  end

  // Scan FSM
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [NDIG-1:0] sel_q, sel_d;
  logic [7:0]      seg_q, seg_d;
  logic            frame_q, frame_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (!en) begin
      // Park in GAP with the counter cleared. A full blank period then runs
      // before the held digit is shown again.
      state_d = ST_GAP;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            frame_d = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The outputs are registered from the next state, so sel/seg change on the
  // same edge as the state. They are decoded from the pre-write register file.
  // A write therefore appears on seg one edge after it lands.
  always_comb begin
    sel_d = '0;
    seg_d = '0;
    if (state_d == ST_SHOW) begin
      sel_d[idx_d] = 1'b1;
      seg_d[7]     = dp_q[idx_d];
      if (lzs && (idx_d != '0) && hi_zero[idx_d]) begin
        seg_d[6:0] = 7'h00;
      end else begin
        seg_d[6:0] = hex7(val_q[idx_d]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_GAP;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      seg_q   <= '0;
      frame_q <= 1'b0;
      dp_q    <= '0;
      for (int i = 0; i < NDIG; i++) begin
        val_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      dp_q    <= dp_d;
      for (int i = 0; i < NDIG; i++) begin
        val_q[i] <= val_d[i];
      end
    end
  end

  assign sel   = sel_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl. A 4-digit instance and a 3-digit instance
// share every input. The 3-digit instance sees wr_addr=3 as out of range.
// Both instances use DWELL=4 and GAP=2. A timeline model predicts sel, seg and
// frame. The model counts enabled cycles since the last restart and derives
// the slot and phase from that count by plain arithmetic.
module tb_seg7_scan_ctrl;

  localparam int DW = 4;
  localparam int GP = 2;
  localparam int P  = DW + GP;

  logic       clk;
  logic       rst;
  logic       en;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       lzs;
  logic [3:0] sel4;
  logic [7:0] seg4;
  logic       frame4;
  logic [2:0] sel3;
  logic [7:0] seg3;
  logic       frame3;

  seg7_scan_ctrl #(.NDIG(4), .DWELL(DW), .GAP(GP)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .lzs(lzs),
    .sel(sel4), .seg(seg4), .frame(frame4)
  );

  seg7_scan_ctrl #(.NDIG(3), .DWELL(DW), .GAP(GP)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .lzs(lzs),
    .sel(sel3), .seg(seg3), .frame(frame3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state for each instance (index 0 = 4 digits, 1 = 3 digits).
  int         nd [2] = '{4, 3};
  int         run [2];
  int         base [2];
  logic [3:0] mval [2][4];
  logic       mdp [2][4];
  logic [3:0] exp_sel [2];
  logic [7:0] exp_seg [2];
  logic       exp_frame [2];
  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72,
                               7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Advance the model by one clock edge, using the inputs as sampled on that
  // edge. The segments come from the register contents before any write.
  task automatic model_step();
    int   slot;
    int   phase;
    int   cur;
    logic all0;
    for (int m = 0; m < 2; m++) begin
      exp_sel[m]   = '0;
      exp_seg[m]   = '0;
      exp_frame[m] = 1'b0;
      if (rst) begin
        run[m]  = 0;
        base[m] = 0;
        for (int j = 0; j < 4; j++) begin
          mval[m][j] = '0;
          mdp[m][j]  = 1'b0;
        end
      end else begin
        if (!en) begin
          base[m] = (base[m] + run[m] / P) % nd[m];
          run[m]  = 0;
        end else begin
          run[m]++;
          slot  = run[m] / P;
          phase = run[m] % P;
          cur   = (base[m] + slot) % nd[m];
          if (phase >= GP) begin
            exp_sel[m] = 4'(1 << cur);
            all0 = 1'b1;
            for (int j = cur; j < nd[m]; j++) begin
              if (mval[m][j] != 4'h0) all0 = 1'b0;
            end
            exp_seg[m] = {mdp[m][cur], (lzs && cur > 0 && all0) ? 7'h00 : seg_tab[mval[m][cur]]};
          end
          if (phase == 0 && slot >= 1 && ((base[m] + slot - 1) % nd[m]) == nd[m] - 1)
            exp_frame[m] = 1'b1;
        end
        if (wr_en && int'(wr_addr) < nd[m]) begin
          mval[m][wr_addr] = wr_data;
          mdp[m][wr_addr]  = wr_dp;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("sel4", 32'(sel4), 32'(exp_sel[0]));
    chk("seg4", 32'(seg4), 32'(exp_seg[0]));
    chk("frame4", 32'(frame4), 32'(exp_frame[0]));
    chk("onehot4", 32'($onehot0(sel4)), 32'd1);
    chk("sel3", 32'(sel3), 32'(exp_sel[1]));
    chk("seg3", 32'(seg3), 32'(exp_seg[1]));
    chk("frame3", 32'(frame3), 32'(exp_frame[1]));
    chk("onehot3", 32'($onehot0(sel3)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic p);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_dp   = p;
    tick();
    wr_en = 1'b0;
    $display("write addr=%0d data=%h dp=%0d", a, d, p);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0; lzs = 1'b0;
    ticks(2);
    chk("rst_sel", 32'(sel4), 32'h0);
    chk("rst_seg", 32'(seg4), 32'h0);
    chk("rst_frame", 32'(frame4), 32'h0);

    // Scenario 1: digits 1,2,3,4. The 3-digit instance drops the write to addr 3.
    rst = 1'b0;
    wr(0, 4'h1, 1'b0); wr(1, 4'h2, 1'b0); wr(2, 4'h3, 1'b0); wr(3, 4'h4, 1'b0);
    en = 1'b1;
    ticks(2);  chk("s1_sel0", 32'(sel4), 32'h1); chk("s1_seg0", 32'(seg4), 32'h30);
    ticks(6);  chk("s1_sel1", 32'(sel4), 32'h2); chk("s1_seg1", 32'(seg4), 32'h6D);
    ticks(6);  chk("s1_sel2", 32'(sel4), 32'h4); chk("s1_seg2", 32'(seg4), 32'h79);
    ticks(6);  chk("s1_sel3", 32'(sel4), 32'h8); chk("s1_seg3", 32'(seg4), 32'h33);
    chk("oor_seg3", 32'(seg3), 32'h30);
    ticks(4);  chk("s1_frame", 32'(frame4), 32'h1);

    // Scenario 2: rewrite digit 2 in mid-dwell.
    ticks(14); chk("s2_pre", 32'(seg4), 32'h79);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'hE; wr_dp = 1'b1;
    tick();
    wr_en = 1'b0;
    $display("write addr=2 data=e dp=1 (mid-dwell)");
    chk("s2_old", 32'(seg4), 32'h79);
    tick();    chk("s2_new", 32'(seg4), 32'hCF); chk("s2_sel", 32'(sel4), 32'h4);

    // Scenario 4: drop en during the dwell of digit 1.
    ticks(17); chk("s4_pre", 32'(sel4), 32'h2);
    en = 1'b0;
    tick();    chk("s4_dark_sel", 32'(sel4), 32'h0); chk("s4_dark_seg", 32'(seg4), 32'h0);
    ticks(2);
    en = 1'b1;
    tick();    chk("s4_gap", 32'(sel4), 32'h0);
    tick();    chk("s4_resume", 32'(sel4), 32'h2); chk("s4_resume_seg", 32'(seg4), 32'h6D);

    // Scenario 3: leading-zero suppression with digits {0,7,0,0}.
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    lzs = 1'b1;
    wr(2, 4'h7, 1'b0);
    en = 1'b1;
    ticks(2);  chk("s3_d0", 32'(seg4), 32'h7E);
    ticks(6);  chk("s3_d1", 32'(seg4), 32'h7E);
    ticks(6);  chk("s3_d2", 32'(seg4), 32'h72);
    ticks(6);  chk("s3_d3", 32'(seg4), 32'h00); chk("s3_d3sel", 32'(sel4), 32'h8);

    // Scenario 5: reset during the dwell of digit 3.
    rst = 1'b1;
    tick();    chk("s5_sel", 32'(sel4), 32'h0); chk("s5_frame", 32'(frame4), 32'h0);
    rst = 1'b0;
    ticks(2);  chk("s5_restart", 32'(seg4), 32'h7E); chk("s5_restart_sel", 32'(sel4), 32'h1);
    ticks(6);  chk("s5_allzero_d1", 32'(seg4), 32'h00);

    // Randomized run that is checked against the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      en      = ($urandom_range(0, 19) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      wr_dp   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) lzs = ~lzs;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a common-segment 7-segment display bank. It holds one hex digit and one decimal-point bit per position in an internal register file and cycles the shared segment bus across the digits one at a time. Each digit is shown for a fixed dwell time, followed by a blanking gap that prevents ghosting. Hex-to-segment decoding uses the team's standard active-high pattern table. Optional leading-zero suppression blanks unused high-order digits.

## Interface
Parameters:
- NDIG, 4: number of digit positions; minimum 2.
- DWELL, 1000: cycles each digit is driven; must be ≥1.
- GAP, 8: blank cycles between digits; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  scan enable; 0 forces the display dark.
- wr_en  in  1  write strobe for the digit register file.
- wr_addr  in  $clog2(NDIG)  digit index; 0 is the least-significant (rightmost) digit.
- wr_data  in  4  hex value to store.
- wr_dp  in  1  decimal-point bit to store.
- lzs  in  1  leading-zero suppression enable.
- sel  out  NDIG  one-hot digit select, active-high, registered.
- seg  out  8  segment bus, registered; {dp, a, b, c, d, e, f, g}, active-high.
- frame  out  1  one-cycle pulse marking the end of each full scan.

## Operation
- Register file: NDIG entries of {dp, value[3:0]}, all cleared by reset. When wr_en=1, the entry at wr_addr is updated on that edge. wr_addr values ≥ NDIG are ignored.
- Decode table for seg[6:0]:
  - 0→7E, 1→30, 2→6D, 3→79, 4→33, 5→5B, 6→5F, 7→72
  - 8→7F, 9→73, A→77, b→1F, C→4E, d→3D, E→4F, F→47
  - seg[7] = the stored dp bit.
- FSM states:
  - GAP: sel=0, seg=0. Counts GAP cycles, then moves to SHOW.
  - SHOW: sel=one-hot(idx), seg=decode(entry[idx]). Counts DWELL cycles, then moves to GAP and advances idx. idx wraps from NDIG-1 to 0.
- Leading-zero suppression: when lzs=1, idx>0, and every entry j ≥ idx has value 0, seg[6:0] is forced to 0; the dp bit is still shown. Digit 0 is never suppressed.
- en=0: on the next edge the FSM enters GAP with its counter cleared, idx is held, and sel=0, seg=0. When en returns to 1, a full GAP runs before the held idx is shown.
- Writes are accepted regardless of en and FSM state.
- frame: asserted for exactly one cycle, on the cycle after the last SHOW cycle of idx=NDIG-1, i.e. the first cycle of the following GAP. Never asserted while en=0.

## Timing
- During reset and on the first cycle after it: sel=0, seg=0, frame=0, state=GAP, counter=0, idx=0, register file all zero.
- After the first edge with rst=0, outputs stay dark for GAP cycles. sel is then one-hot for exactly DWELL cycles, followed by GAP dark cycles.
- Per-digit period is DWELL+GAP cycles; frame period is NDIG*(DWELL+GAP) cycles.
- sel and seg change on the same edge. sel is never multi-hot, and sel/seg are never nonzero while the FSM is in GAP.
- Write latency: for wr_en at edge t, the register file updates at t. If that digit is being shown, seg reflects the new value at edge t+1. A write during SHOW changes seg in mid-dwell without altering dwell timing.
- A write on the same edge that the FSM enters SHOW for the same index: the new value is shown from the following cycle onward. The first SHOW cycle may show the old value.
- rst mid-scan overrides everything: next cycle matches the post-reset state, including a cleared register file.
- en and rst asserted together: rst wins.

## Test plan
(NDIG=4, DWELL=4, GAP=2 for all scenarios.)
1. Reset, write digits 0..3 = 1, 2, 3, 4, en=1, lzs=0:
   - 2 dark cycles, then sel=0001/seg=30 for 4 cycles.
   - 2 dark cycles, then 0010/6D ×4, 0100/79 ×4, 1000/33 ×4.
   - frame pulses once; the 24-cycle period repeats.
2. Write digit 2 = E with dp=1 while digit 2 is shown → seg becomes CF one cycle after the write edge; sel timing unchanged.
3. lzs=1, digits = {0, 0, 7, 0} (idx 3..0) → idx 3 seg=00, idx 2 seg=72, idx 1 seg=7E, idx 0 seg=7E. With lzs=1 and all digits zero, only idx 0 shows 7E.
4. Drop en for 3 cycles mid-dwell of idx 1:
   - sel=0 and seg=0 starting the next cycle; no frame pulse.
   - After en returns: 2 dark cycles, then idx 1 is shown for a full 4 cycles.
5. Assert rst during SHOW of idx 3 → next cycle sel=0, seg=0, and frame stays 0. The scan restarts at idx 0 showing 7E after 2 dark cycles.
6. Write with wr_addr out of range (NDIG=3 build, wr_addr=3) → no entry changes. Across all runs, check that sel is always one-hot-or-zero.
